// File: rtl/softmax_norm_buf.sv
// softmax_norm_buf
//
// Softmax vector buffer and normaliser wrapped around a Newton-Raphson
// reciprocal unit (nr_recip). A vector of signed Q exponentials is streamed in,
// stored in an inferred block RAM, and summed with saturation. The sum is
// handed to nr_recip with a one-cycle start pulse. When the reciprocal comes
// back, each stored element is multiplied by it, rounded half-up, saturated,
// and streamed out in write order.
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   exp_valid/exp_data/exp_last/exp_ready : input vector stream
//   recip_start, recip_a_q: start pulse and operand (sum) towards nr_recip
//   recip_done, recip_y_q : reciprocal result from nr_recip
//   out_valid/out_data/out_last/out_ready : normalised output stream
//   busy                  : high whenever a vector is in flight
//   len_err               : sticky flag, set when a vector overruns DEPTH
module softmax_norm_buf #(
    parameter int WIDTH  = 32,
    parameter int Q      = 26,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exp_valid,
    input  logic [WIDTH-1:0] exp_data,
    input  logic             exp_last,
    output logic             exp_ready,
    output logic             recip_start,
    output logic [WIDTH-1:0] recip_a_q,
    input  logic             recip_done,
    input  logic [WIDTH-1:0] recip_y_q,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             len_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        WAIT_R = 3'd3,
        NORM   = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]    LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [WIDTH-1:0]   SAT_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   SAT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [2*WIDTH:0] ROUND = (2*WIDTH+1)'(1) << (Q - 1);

    state_t state_reg, state_next;

    // Element count and read pointer need one extra bit to represent DEPTH.
    logic [ADDR_W:0]  count_reg;
    logic [ADDR_W:0]  rd_ptr_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             sat_reg;
    logic [WIDTH-1:0] recip_reg;
    logic             len_err_reg;

    // Read stage (RAM output register) and output register.
    logic [WIDTH-1:0] rd_data_reg;
    logic             rd_valid_reg;
    logic             rd_last_reg;
    logic             out_valid_reg;
    logic             out_last_reg;
    logic [WIDTH-1:0] out_data_reg;

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    logic              accept;
    logic              overrun;
    logic              advance;
    logic              rd_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH:0]    sum_ext;
    logic              sum_ovf;
    logic [WIDTH-1:0]  sum_add;

    logic signed [2*WIDTH-1:0] elem_ext;
    logic signed [2*WIDTH-1:0] recip_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH:0]   rnd;
    logic signed [2*WIDTH:0]   rnd_sh;
    logic [WIDTH+1:0]          rnd_upper;
    logic [WIDTH-1:0]          norm_val;

    // ------------------------------------------------------------------
    // Next-state logic and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        exp_ready   = 1'b0;
        recip_start = 1'b0;
        busy        = 1'b1;
        case (state_reg)
            IDLE: begin
                exp_ready = 1'b1;
                busy      = 1'b0;
                if (exp_valid) begin
                    state_next = exp_last ? START : LOAD;
                end
            end
            LOAD: begin
                exp_ready = 1'b1;
                // A beat that fills the buffer closes the vector even without exp_last.
                if (exp_valid && (exp_last || count_reg == LAST_IDX)) begin
                    state_next = START;
                end
            end
            START: begin
                recip_start = 1'b1;
                state_next  = WAIT_R;
            end
            WAIT_R: begin
                if (recip_done) begin
                    state_next = NORM;
                end
            end
            NORM: begin
                if (out_valid_reg && out_ready && out_last_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Input side: write address, saturating accumulation
    // ------------------------------------------------------------------
    assign accept  = exp_valid && exp_ready;
    assign overrun = (state_reg == LOAD) && accept && !exp_last && (count_reg == LAST_IDX);
    assign wr_addr = (state_reg == IDLE) ? '0 : count_reg[ADDR_W-1:0];

    assign sum_ext = {sum_reg[WIDTH-1], sum_reg} + {exp_data[WIDTH-1], exp_data};
    assign sum_ovf = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
    assign sum_add = sum_ovf ? (sum_ext[WIDTH] ? SAT_MIN : SAT_MAX) : sum_ext[WIDTH-1:0];

    // ------------------------------------------------------------------
    // Output side: a read is only issued when the output register can take
    // the data currently in the read stage, so the two-stage pipe never
    // drops or duplicates an element under backpressure.
    // ------------------------------------------------------------------
    assign advance = !out_valid_reg || out_ready;
    assign rd_en   = (state_reg == NORM) && advance && (rd_ptr_reg < count_reg);

    // Buffer RAM: synchronous write, registered read with enable so the read
    // register holds its value while the output is stalled.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= exp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
        end
    end

    // Full-width signed product; sign-extending both operands to 2*WIDTH
    // keeps the low 2*WIDTH bits of the product exact.
    assign elem_ext  = {{WIDTH{rd_data_reg[WIDTH-1]}}, rd_data_reg};
    assign recip_ext = {{WIDTH{recip_reg[WIDTH-1]}}, recip_reg};
    assign prod      = elem_ext * recip_ext;
    assign rnd       = $signed({prod[2*WIDTH-1], prod}) + ROUND;
    assign rnd_sh    = rnd >>> Q;
    // The result fits in WIDTH bits when everything above bit WIDTH-2 is a
    // copy of the sign.
    assign rnd_upper = rnd_sh[2*WIDTH:WIDTH-1];
    assign norm_val  = ((rnd_upper == '0) || (rnd_upper == '1)) ? rnd_sh[WIDTH-1:0]
                     : (rnd_sh[2*WIDTH] ? SAT_MIN : SAT_MAX);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg     <= '0;
            sum_reg       <= '0;
            sat_reg       <= 1'b0;
            recip_reg     <= '0;
            len_err_reg   <= 1'b0;
            rd_ptr_reg    <= '0;
            rd_valid_reg  <= 1'b0;
            rd_last_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            if (accept) begin
                if (state_reg == IDLE) begin
                    sum_reg   <= exp_data;
                    sat_reg   <= 1'b0;
                    count_reg <= (ADDR_W+1)'(1);
                end else begin
                    count_reg <= count_reg + 1'b1;
                    // Once saturated, the sum is frozen for the rest of the vector.
                    if (!sat_reg) begin
                        sum_reg <= sum_add;
                        sat_reg <= sum_ovf;
                    end
                end
            end

            if (overrun) begin
                len_err_reg <= 1'b1;
            end

            if (state_reg == WAIT_R && recip_done) begin
                recip_reg  <= recip_y_q;
                rd_ptr_reg <= '0;
            end else if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end

            if (advance) begin
                rd_valid_reg  <= rd_en;
                rd_last_reg   <= rd_en && (rd_ptr_reg == count_reg - 1'b1);
                out_valid_reg <= rd_valid_reg;
                out_last_reg  <= rd_valid_reg && rd_last_reg;
                if (rd_valid_reg) begin
                    out_data_reg <= norm_val;
                end
            end
        end
    end

    assign recip_a_q = sum_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign len_err   = len_err_reg;

endmodule

// File: tb/tb_softmax_norm_buf.sv
// Testbench for softmax_norm_buf: directed vectors with a behavioural model
// (saturating sum, round-half-up normalisation) and a per-cycle compare
// process, plus hand-computed literal expectations.
module tb_softmax_norm_buf;

    localparam int WIDTH  = 32;
    localparam int Q      = 26;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam logic [15:0] READY_PAT = 16'b1001_1101_0010_1101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exp_valid, exp_last, exp_ready;
    logic [31:0] exp_data;
    logic        recip_start, recip_done;
    logic [31:0] recip_a_q, recip_y_q;
    logic        out_valid, out_last, out_ready;
    logic [31:0] out_data;
    logic        busy, len_err;

    softmax_norm_buf #(.WIDTH(WIDTH), .Q(Q), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .exp_valid(exp_valid), .exp_data(exp_data), .exp_last(exp_last), .exp_ready(exp_ready),
        .recip_start(recip_start), .recip_a_q(recip_a_q),
        .recip_done(recip_done), .recip_y_q(recip_y_q),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        bit          last;
    } beat_t;

    beat_t       beat_q[$];
    beat_t       exp_q[$];
    logic [31:0] sum_q[$];
    logic [31:0] recip_q[$];
    logic [31:0] got_q[$];
    logic [31:0] got_sums[$];
    logic [31:0] vec[$];
    int          n_checks = 0;
    int          n_pass = 0;
    bit          ready_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, req);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] model_sum();
        longint s = 0;
        bit     sat = 1'b0;
        foreach (vec[i]) begin
            if (!sat) begin
                s = s + longint'($signed(vec[i]));
                if (s > 64'sd2147483647) begin s = 64'sd2147483647; sat = 1'b1; end
                else if (s < -64'sd2147483648) begin s = -64'sd2147483648; sat = 1'b1; end
            end
        end
        return s[31:0];
    endfunction

    function automatic logic [31:0] model_norm(input logic [31:0] e, input logic [31:0] r);
        longint p;
        p = longint'($signed(e)) * longint'($signed(r));
        p = (p + (64'sd1 <<< (Q - 1))) >>> Q;
        if (p > 64'sd2147483647) p = 64'sd2147483647;
        if (p < -64'sd2147483648) p = -64'sd2147483648;
        return p[31:0];
    endfunction

    // Queue the current vec as one vector: beats, expected sum, reciprocal to
    // return, and expected outputs.
    task automatic add_vec(input logic [31:0] r, input bit mark_last);
        beat_t b;
        beat_t eo;
        sum_q.push_back(model_sum());
        recip_q.push_back(r);
        foreach (vec[i]) begin
            eo.d    = model_norm(vec[i], r);
            eo.last = (i == vec.size() - 1);
            exp_q.push_back(eo);
        end
        foreach (vec[i]) begin
            b.d    = vec[i];
            b.last = mark_last && (i == vec.size() - 1);
            beat_q.push_back(b);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (k < budget && !(beat_q.size() == 0 && exp_q.size() == 0 && recip_q.size() == 0 &&
                               sum_q.size() == 0 && !busy && !exp_valid)) begin
            @(negedge clk);
            k++;
        end
        chk1({"idle_", name}, k < budget, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- input driver ----------------
    initial begin
        bit took;
        exp_valid = 1'b0; exp_data = '0; exp_last = 1'b0;
        forever begin
            @(negedge clk);
            took = rst_n && exp_valid && exp_ready;
            @(posedge clk); #1;
            if (took) void'(beat_q.pop_front());
            if (rst_n && beat_q.size() > 0) begin
                exp_valid = 1'b1; exp_data = beat_q[0].d; exp_last = beat_q[0].last;
            end else begin
                exp_valid = 1'b0; exp_data = '0; exp_last = 1'b0;
            end
        end
    end

    // ---------------- reciprocal responder ----------------
    initial begin
        logic [31:0] r;
        recip_done = 1'b0; recip_y_q = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            if (rst_n && recip_start) begin
                if (recip_q.size() > 0) r = recip_q.pop_front();
                else begin
                    n_checks++;
                    $display("FAIL recip_start: unexpected pulse, no vector pending");
                    r = 32'h0;
                end
                @(posedge clk); @(posedge clk); #1;
                recip_done = 1'b1; recip_y_q = r;
                @(posedge clk); #1;
                recip_done = 1'b0; recip_y_q = 32'hDEADBEEF;
            end
        end
    end

    // ---------------- out_ready driver ----------------
    initial begin
        logic [15:0] pat;
        int k = 0;
        pat = READY_PAT;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = ready_mode ? pat[k % 16] : 1'b1;
            k++;
        end
    end

    // ---------------- per-cycle compare process ----------------
    int          in_cnt = 0;
    bit          start_due = 1'b0;
    bit          lat_arm = 1'b0;
    int          lat_n = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    beat_t       mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_cnt = 0; start_due = 1'b0; lat_arm = 1'b0; prev_stall = 1'b0;
        end else begin
            chk1("recip_start_timing", recip_start, start_due);
            if (recip_start) begin
                if (sum_q.size() > 0) chk("recip_a_q", recip_a_q, sum_q.pop_front());
                else begin
                    n_checks++;
                    $display("FAIL recip_a_q: got 0x%08h, no sum expected", recip_a_q);
                end
                got_sums.push_back(recip_a_q);
            end
            start_due = 1'b0;
            if (exp_valid && exp_ready) begin
                in_cnt++;
                if (exp_last || in_cnt == DEPTH) begin start_due = 1'b1; in_cnt = 0; end
            end
            if (lat_arm) begin
                lat_n++;
                if (out_valid) begin
                    chk("first_out_latency", 32'(lat_n), 32'd3);
                    lat_arm = 1'b0;
                end
            end
            if (recip_done) begin lat_arm = 1'b1; lat_n = 0; end
            if (prev_stall) begin
                chk1("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, prev_data);
                chk1("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", out_data, mon_e.d);
                    chk1("out_last", out_last, mon_e.last);
                end else begin
                    n_checks++;
                    $display("FAIL out_beat: got 0x%08h, expected no beat", out_data);
                end
                got_q.push_back(out_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_exp_ready"}, exp_ready, 1'b1);
        chk1({tag, "_recip_start"}, recip_start, 1'b0);
        chk({tag, "_recip_a_q"}, recip_a_q, 32'h0);
        chk1({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"}, out_data, 32'h0);
        chk1({tag, "_out_last"}, out_last, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_len_err"}, len_err, 1'b0);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("release_exp_ready", exp_ready, 1'b1);

        // Pin the model with hand-computed values.
        chk("pin_norm_1", model_norm(32'h08000000, 32'h02000000), 32'h04000000);
        chk("pin_norm_half_up", model_norm(32'h00000003, 32'h02000000), 32'h00000002);
        chk("pin_norm_neg_half", model_norm(32'hFFFFFFFF, 32'h02000000), 32'h00000000);
        chk("pin_norm_sat", model_norm(32'h60000000, 32'h10000000), 32'h7FFFFFFF);
        vec = {32'h60000000, 32'h60000000, 32'hC0000000};
        chk("pin_sum_sticky", model_sum(), 32'h7FFFFFFF);

        // T1: four beats of 1.0, reciprocal 1/16.
        got_q.delete(); got_sums.delete();
        vec = {32'h04000000, 32'h04000000, 32'h04000000, 32'h04000000};
        add_vec(32'h01000000, 1'b1);
        wait_idle("t1", 500);
        chk("t1_sum", got_sums[0], 32'h10000000);
        chk("t1_count", 32'(got_q.size()), 32'd4);
        chk("t1_out0", got_q[0], 32'h01000000);
        chk("t1_out3", got_q[3], 32'h01000000);

        // T2: single element vector.
        got_q.delete(); got_sums.delete();
        vec = {32'h08000000};
        add_vec(32'h02000000, 1'b1);
        wait_idle("t2", 500);
        chk("t2_sum", got_sums[0], 32'h08000000);
        chk("t2_out0", got_q[0], 32'h04000000);

        // T3: sum saturates and stays saturated; outputs saturate both ways.
        got_q.delete(); got_sums.delete();
        vec = {32'h60000000, 32'h60000000, 32'hC0000000};
        add_vec(32'h10000000, 1'b1);
        wait_idle("t3", 500);
        chk("t3_sum", got_sums[0], 32'h7FFFFFFF);
        chk("t3_out0", got_q[0], 32'h7FFFFFFF);
        chk("t3_out2", got_q[2], 32'h80000000);

        // T4: eight elements with a stalling downstream.
        got_q.delete(); got_sums.delete();
        ready_mode = 1'b1;
        vec = {32'h04000000, 32'h00000003, 32'hFFFFFFFF, 32'hFE000000,
               32'h12345678, 32'h00000001, 32'h7FFFFFFF, 32'h00800000};
        add_vec(32'h02000000, 1'b1);
        wait_idle("t4", 1000);
        ready_mode = 1'b0;
        chk("t4_count", 32'(got_q.size()), 32'd8);
        chk("t4_out1", got_q[1], 32'h00000002);
        chk("t4_out2", got_q[2], 32'h00000000);
        chk("t4_out5", got_q[5], 32'h00000001);
        chk("t4_out6", got_q[6], 32'h40000000);
        chk1("t4_len_err", len_err, 1'b0);

        // T5: 64 beats without exp_last, then a 65th beat that is its own vector.
        got_q.delete(); got_sums.delete();
        vec.delete();
        for (int i = 0; i < 64; i++) vec.push_back(32'(i + 1) << 16);
        add_vec(32'h04000000, 1'b0);
        vec = {32'h04000000};
        add_vec(32'h01000000, 1'b1);
        wait_idle("t5", 2000);
        chk("t5_sum_a", got_sums[0], 32'h08200000);
        chk("t5_sum_b", got_sums[1], 32'h04000000);
        chk("t5_count", 32'(got_q.size()), 32'd65);
        chk("t5_out63", got_q[63], 32'h00400000);
        chk("t5_out64", got_q[64], 32'h01000000);
        chk1("t5_len_err", len_err, 1'b1);

        // T6: reset while the third output of an eight-element vector is presented.
        got_q.delete(); got_sums.delete();
        vec = {32'h01000000, 32'h02000000, 32'h03000000, 32'h04000000,
               32'h05000000, 32'h06000000, 32'h07000000, 32'h08000000};
        add_vec(32'h04000000, 1'b1);
        k = 0;
        while (k < 1000 && !(got_q.size() == 2 && out_valid)) begin
            @(posedge clk); #2;
            k++;
        end
        chk("t6_outputs_before_reset", 32'(got_q.size()), 32'd2);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_reset");
        exp_q.delete(); sum_q.delete(); recip_q.delete(); beat_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk1("t6_quiet_after_reset", out_valid, 1'b0);
        chk("t6_no_beats_after_reset", 32'(got_q.size()), 32'd2);

        got_q.delete(); got_sums.delete();
        vec = {32'h02000000, 32'h06000000};
        add_vec(32'h02000000, 1'b1);
        wait_idle("t6b", 500);
        chk("t6b_sum", got_sums[0], 32'h08000000);
        chk("t6b_out0", got_q[0], 32'h01000000);
        chk("t6b_out1", got_q[1], 32'h03000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/softmax_norm_buf.md
# softmax_norm_buf

Softmax vector buffer and normaliser, wrapped around the Newton-Raphson reciprocal unit. It accepts a stream of Q6.26 exponentials, stores them, and accumulates their sum. It then hands the sum to `nr_recip` as a start pulse plus operand and waits for the reciprocal. Finally it streams back each stored exponential multiplied by the reciprocal as the softmax output vector.

## Interface
- `WIDTH`, 32, data width of every fixed-point word (signed, two's complement)
- `Q`, 26, fractional bits (Q6.26 at default)
- `DEPTH`, 64, maximum vector length held in the buffer
- `ADDR_W`, 6, buffer address width; DEPTH = 2**ADDR_W
- `clk` in 1: the block's one clock, rising-edge
- `rst_n` in 1: reset, asynchronous and active-low
- `exp_valid` in 1: input beat valid
- `exp_data` in WIDTH: exponential value, signed Q
- `exp_last` in 1: marks final element of the vector
- `exp_ready` out 1: block accepts an input beat
- `recip_start` out 1: one-cycle start pulse to `nr_recip`
- `recip_a_q` out WIDTH: sum of the vector; held stable from the pulse until capture
- `recip_done` in 1: reciprocal valid, from `nr_recip` done
- `recip_y_q` in WIDTH: reciprocal, signed Q
- `out_valid` out 1: normalised beat valid
- `out_data` out WIDTH: softmax element, signed Q
- `out_last` out 1: final element of the output vector
- `out_ready` in 1: downstream accepts the beat
- `busy` out 1: high in every state except IDLE
- `len_err` out 1: sticky; set on buffer overrun, cleared only by reset

## Operation
- States: IDLE, LOAD, START, WAIT_R, NORM.
- IDLE:
  - `exp_ready`=1.
  - First accepted beat writes addr 0, sets sum=`exp_data`, count=1, and moves to LOAD. If that beat has `exp_last`, go to START instead.
- LOAD:
  - `exp_ready`=1.
  - Each accepted beat writes addr count, adds to sum, and increments count.
  - The beat with `exp_last` → START.
  - The beat that makes count==DEPTH without `exp_last`: treat it as last, set `len_err`, → START. Beats arriving after that belong to the next vector.
- Sum accumulation: WIDTH+1-bit add, saturating to 0x7FFFFFFF or 0x80000000. Once saturated, the sum stays saturated for the rest of the vector.
- START:
  - `recip_start`=1 for exactly one cycle.
  - `recip_a_q`=sum, held until the reciprocal is captured.
  - → WAIT_R.
- WAIT_R: `exp_ready`=0. On `recip_done`=1, capture `recip_y_q` into the recip register → NORM.
- `recip_done` in any state other than WAIT_R is ignored.
- NORM: elements are read in write order, addr 0..count-1.
  - Product = full 2·WIDTH signed multiply of element × recip.
  - Add 2**(Q-1) for round-half-up, arithmetic shift right by Q.
  - Saturate to the signed WIDTH range.
  - `out_last`=1 on element count-1.
- The handshake on the last element → IDLE. `exp_ready` rises on the next cycle.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_last` and `out_valid` hold. No element is dropped or duplicated.

## Timing
- Reset (async assert):
  - State=IDLE.
  - `exp_ready`=1 after release; `recip_start`=0, `recip_a_q`=0.
  - `out_valid`=0, `out_data`=0, `out_last`=0.
  - `busy`=0, `len_err`=0.
  - Count, sum and the recip register are cleared; buffer contents are don't-care.
- Reset asserted in any state aborts the vector; no further output beats appear.
- Last input beat accepted at edge E:
  - `recip_start` is high during cycle E+1.
  - WAIT_R begins at E+2.
- `recip_done` sampled at edge R → first `out_valid` at R+2: one cycle of synchronous RAM read, then the registered multiply.
- With `out_ready` held at 1: one beat per cycle, count beats back to back.
- A buffer read may be issued only when the output register is empty or is being drained in the same cycle.
- One vector in flight at a time: no new input is accepted in START, WAIT_R or NORM.

## Test plan
- Four beats of 0x04000000 (1.0), last on 4th → `recip_a_q`=0x10000000 with a single `recip_start` pulse. Drive `recip_y_q`=0x01000000 → four outputs of 0x01000000, `out_last` on 4th only.
- Single beat 0x08000000 with `exp_last` → `recip_a_q`=0x08000000. Drive recip 0x02000000 → one output 0x04000000 with `out_last`=1.
- Beats 0x60000000, 0x60000000 → `recip_a_q`=0x7FFFFFFF. Then beat 0x40000000 × recip 0x10000000 → `out_data`=0x7FFFFFFF (saturated).
- Eight-element vector with `out_ready` toggling 1,0,0,1 pseudo-randomly → all eight values appear in order, each exactly once, and are stable while stalled.
- 64 beats with no `exp_last` → `len_err`=1 and START is entered after the 64th beat. 65th beat is stalled until IDLE, then processed as a new vector.
- `rst_n` dropped at the 3rd output of an 8-element vector → all outputs take their reset values immediately. A fresh 2-element vector afterwards then completes correctly.
